// File: rtl/upcnt_main_if.sv
// ---------------------------------------------------------------------------
// upcnt_main_if
// Purpose: groups the control and status signals of the 4-bit programmable
//          up-counter so that producer and counter share one bundle.
// Signals:
//   en      count enable (one increment per clock when high)
//   ld      synchronous load strobe, captures din into the count
//   din     [3:0] load value
//   term    [3:0] programmable terminal count
//   clr_ovf synchronous clear of the sticky wrap flag
//   q       [3:0] current count (registered)
//   co      carry-out, combinational: en & ~ld & (q == term)
//   ovf     sticky terminal-wrap flag (registered)
// Modports:
//   master  drives the controls and observes the status (bench or parent block)
//   slave   the counter itself
// ---------------------------------------------------------------------------
interface upcnt_main_if;
  logic       en;
  logic       ld;
  logic [3:0] din;
  logic [3:0] term;
  logic       clr_ovf;
  logic [3:0] q;
  logic       co;
  logic       ovf;

  modport master (
    output en, ld, din, term, clr_ovf,
    input  q, co, ovf
  );

  modport slave (
    input  en, ld, din, term, clr_ovf,
    output q, co, ovf
  );
endinterface

// File: rtl/upcnt_main.sv
// ---------------------------------------------------------------------------
// upcnt_main
// Purpose: 4-bit up-counter with a programmable terminal count, a synchronous
//          load, a combinational carry-out and a sticky wrap flag.
// Ports:
//   clk  single clock; all state updates on the rising edge
//   rst  asynchronous, active-low reset (q = 0, ovf = 0 immediately)
//   bus  upcnt_main_if.slave: en, ld, din, term, clr_ovf in; q, co, ovf out
// Behaviour per clock: ld wins over en, en wins over hold. With en high the
// count wraps to 0 at q == term (co pulses, ovf sets); if term is below the
// current count the counter runs to 15 and rolls over naturally, which
// neither pulses co nor sets ovf.
// ---------------------------------------------------------------------------
module upcnt_main (
  input  logic        clk,
  input  logic        rst,
  upcnt_main_if.slave bus
);

  localparam int CNT_W = 4;

  logic [CNT_W-1:0] q_q;
  logic [CNT_W-1:0] q_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             term_hit;
  logic             wrap;
  logic [CNT_W-1:0] q_inc;

  // Ripple-carry increment: bit i toggles when the carry-in and all lower
  // bits are 1. With cin = 0 the value passes through unchanged, so the same
  // chain covers both the counting and the holding case. 15 + 1 rolls over
  // to 0 on its own, giving the natural rollover without extra muxing.
  function automatic logic [CNT_W-1:0] ripple_inc(
    input logic [CNT_W-1:0] v,
    input logic             cin
  );
    logic             c;
    logic [CNT_W-1:0] r;
    c = cin;
    r = '0;
    for (int i = 0; i < CNT_W; i++) begin
      r[i] = v[i] ^ c;
      c    = c & v[i];
    end
    return r;
  endfunction

  always_comb begin
    term_hit = (q_q == bus.term);
    // A terminal wrap only happens on an enabled, non-load cycle.
    wrap     = bus.en & ~bus.ld & term_hit;
    q_inc    = ripple_inc(q_q, bus.en);

    q_d = q_inc;
    if (bus.ld) begin
      q_d = bus.din;
    end else if (wrap) begin
      q_d = '0;
    end

    // Set has priority over clear so a wrap coinciding with clr_ovf is kept.
    ovf_d = wrap | (ovf_q & ~bus.clr_ovf);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.q   = q_q;
  assign bus.ovf = ovf_q;
  // The carry-out is the unregistered wrap condition; it follows q/en/ld/term
  // within the same cycle, including while rst is asserted.
  assign bus.co  = wrap;

endmodule

// File: tb/tb_upcnt_main.sv
// ---------------------------------------------------------------------------
// tb_upcnt_main
// Self-checking bench for upcnt_main. A behavioural model of the counter
// (plain arithmetic on integers) predicts q, co and ovf each cycle; directed
// scenarios cover the documented corner cases, then randomized traffic
// exercises load/enable/clear/term changes.
// ---------------------------------------------------------------------------
module tb_upcnt_main;

  logic clk = 1'b0;
  logic rst;

  upcnt_main_if bus ();

  upcnt_main dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int mq  = 0;
  int mov = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic en, input logic ld, input int din,
                     input int term, input logic clr);
    bus.en      = en;
    bus.ld      = ld;
    bus.din     = 4'(din);
    bus.term    = 4'(term);
    bus.clr_ovf = clr;
  endtask

  // Called at posedge+1 with inputs already driven. Checks co mid-cycle,
  // advances the model, then checks q and ovf just after the next edge.
  task automatic step(input string tag);
    int exp_co;
    int t;
    #4;
    t      = int'(bus.term);
    exp_co = (bus.en && !bus.ld && (mq == t)) ? 1 : 0;
    chk({tag, ".co"}, {31'b0, bus.co}, exp_co);
    if (exp_co == 1)       mov = 1;
    else if (bus.clr_ovf)  mov = 0;
    if (bus.ld)            mq = int'(bus.din);
    else if (bus.en)       mq = (mq == t) ? 0 : (mq + 1) % 16;
    @(posedge clk);
    #1;
    chk({tag, ".q"},   {28'b0, bus.q}, mq);
    chk({tag, ".ovf"}, {31'b0, bus.ovf}, mov);
  endtask

  initial begin
    drv(1'b0, 1'b0, 0, 0, 1'b0);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("reset.q",   {28'b0, bus.q}, 0);
    chk("reset.ovf", {31'b0, bus.ovf}, 0);

    // Controls are ignored while reset is held.
    drv(1'b1, 1'b1, 9, 9, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold.q",   {28'b0, bus.q}, 0);
    chk("reset_hold.ovf", {31'b0, bus.ovf}, 0);
    // term=0, en=1, ld=0 during reset: co evaluates high.
    drv(1'b1, 1'b0, 0, 0, 1'b0);
    #1;
    chk("reset_co_term0", {31'b0, bus.co}, 1);
    drv(1'b0, 1'b0, 0, 0, 1'b0);
    rst = 1'b1;
    mq  = 0;
    mov = 0;

    // Terminal count 5, 12 enabled clocks.
    for (int i = 0; i < 12; i++) begin
      drv(1'b1, 1'b0, 0, 5, 1'b0);
      step("term5");
    end

    // Load 9 with en high and term 9, then wrap.
    drv(1'b1, 1'b1, 9, 9, 1'b0);
    step("ld9");
    drv(1'b1, 1'b0, 0, 9, 1'b0);
    step("ld9_wrap");

    // Load 12 with term 3: natural rollover, then terminal wrap.
    drv(1'b0, 1'b1, 12, 3, 1'b1);
    step("ld12");
    for (int i = 0; i < 8; i++) begin
      drv(1'b1, 1'b0, 0, 3, 1'b0);
      step("term3");
    end

    // Wrap coinciding with clr_ovf keeps ovf; clr_ovf alone clears it.
    drv(1'b0, 1'b1, 5, 5, 1'b0);
    step("pre_clr");
    drv(1'b1, 1'b0, 0, 5, 1'b1);
    step("wrap_and_clr");
    drv(1'b0, 1'b0, 0, 5, 1'b1);
    step("clr_alone");

    // term = 0: q stays 0, co every enabled cycle; en low drops co.
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, 1'b0, 0, 0, 1'b0);
      step("term0");
    end
    drv(1'b0, 1'b0, 0, 0, 1'b1);
    step("term0_off");

    // Async reset mid-cycle with q = 7 and ovf = 1.
    drv(1'b0, 1'b1, 2, 2, 1'b0);
    step("pre_rst_a");
    drv(1'b1, 1'b0, 0, 2, 1'b0);
    step("pre_rst_b");
    drv(1'b0, 1'b1, 7, 2, 1'b0);
    step("pre_rst_c");
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst.q",   {28'b0, bus.q}, 0);
    chk("async_rst.ovf", {31'b0, bus.ovf}, 0);
    mq  = 0;
    mov = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 1'b0, 0, 9, 1'b0);
      step("after_rst");
    end

    // Randomized traffic, including term changes below the running count.
    for (int i = 0; i < 400; i++) begin
      drv(($urandom_range(0, 9) != 0),
          ($urandom_range(0, 7) == 0),
          int'($urandom_range(0, 15)),
          ((i % 16) == 0) ? int'($urandom_range(0, 15)) : int'(bus.term),
          ($urandom_range(0, 7) == 0));
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/upcnt_main.md
UPCNT_MAIN -- requirements
Module: upcnt_main

Interface
REQ-001 Parameter: none; the count width SHALL be fixed at 4 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; low forces reset state immediately.
REQ-004 en  input  1  count enable; high SHALL advance the count by one per clock.
REQ-005 ld  input  1  synchronous load strobe.
REQ-006 din  input  4  value captured into q when ld is high.
REQ-007 term  input  4  programmable terminal count.
REQ-008 clr_ovf  input  1  synchronous clear of the sticky ovf flag.
REQ-009 q  output  4  current count, registered.
REQ-010 co  output  1  carry-out, combinational: co = en & ~ld & (q == term).
REQ-011 ovf  output  1  sticky wrap flag, registered.

Function
REQ-012 Priority per clock SHALL be: ld, then en, then hold.
REQ-013 ld high: next q = din regardless of en; co SHALL be 0 in that cycle; ovf unchanged except by clr_ovf.
REQ-014 ld low, en high, q != term, q != 15: next q = q + 1.
REQ-015 ld low, en high, q == term: next q = 0 (terminal wrap); co = 1 in that cycle; ovf set at the same edge.
REQ-016 ld low, en high, q == 15, term != 15: next q = 0 (natural rollover); co = 0; ovf SHALL NOT be set.
REQ-017 ld low, en low: q holds; co = 0.
REQ-018 Period with en held high and q starting at 0 SHALL be term + 1 clocks; co high exactly one clock per period.
REQ-019 term = 0: q stays 0 while enabled; co SHALL be high every enabled cycle.
REQ-020 term changed mid-count below current q: counter continues to 15, rolls over to 0, then wraps at new term (per REQ-016).
REQ-021 Next-state logic SHALL be a ripple-carry chain: toggle bit i when en and bits 0..i-1 are all 1, as in the team's existing counter, plus wrap/load muxing.
REQ-022 ovf: set on terminal wrap (REQ-015); cleared by clr_ovf; set and clr_ovf in the same cycle SHALL leave ovf = 1 (set wins).
REQ-023 Latency: ld and count effects SHALL appear on q one clock after the sampling edge; co SHALL reflect the current q/en/ld/term with no register delay.
REQ-024 No X propagation: every register SHALL have a defined reset value.

Reset
REQ-025 rst low SHALL asynchronously force q = 0000 and ovf = 0; co then evaluates to 0 unless term = 0 and en = 1 with ld = 0.
REQ-026 While rst is low, ld, en, and clr_ovf SHALL be ignored.
REQ-027 Reset release SHALL be clean: the first rising edge with rst high performs a normal update.
REQ-028 Reset asserted mid-count SHALL abort the count without a co pulse being registered into ovf.

Verification
REQ-029 Reset, then term = 5, en = 1 for 12 clocks: q = 0,1,2,3,4,5,0,1,2,3,4,5; co high at q = 5 (twice); ovf = 1 after the first wrap.
REQ-030 ld = 1 with din = 9 and en = 1 simultaneously, term = 9: q = 9 next clock; co = 0 during the load cycle; co = 1 on the following enabled cycle; q then wraps to 0.
REQ-031 term = 3, ld din = 12, en = 1: q = 12,13,14,15,0,1,2,3,0; co only at q = 3; ovf set only after 3 -> 0.
REQ-032 ovf = 1, then clr_ovf = 1 on the same cycle as a terminal wrap: ovf stays 1; clr_ovf alone next cycle: ovf = 0.
REQ-033 term = 0, en = 1: q stays 0, co = 1 every cycle; en = 0: co = 0.
REQ-034 rst pulled low between clock edges with q = 7: q = 0 and ovf = 0 immediately, without waiting for an edge; after release, counting resumes from 0.
